// File: rtl/flash_pkg.sv
// ----------------------------------------------------------------------------
// flash_pkg
// Shared definitions for the parallel NOR flash pin interface: command codes,
// status register bit positions, identifier bytes and the command state
// encoding. The Flash controller imports the same state encoding so both ends
// of the bus agree on mode names.
// No ports (package).
// ----------------------------------------------------------------------------
package flash_pkg;

    // Command bytes carried on the data lines of a write event
    localparam logic [7:0] CMD_READ_ARRAY  = 8'hFF;
    localparam logic [7:0] CMD_READ_STATUS = 8'h70;
    localparam logic [7:0] CMD_READ_ID     = 8'h90;
    localparam logic [7:0] CMD_CLEAR_SR    = 8'h50;
    localparam logic [7:0] CMD_PROGRAM     = 8'h40;
    localparam logic [7:0] CMD_PROGRAM_ALT = 8'h10;
    localparam logic [7:0] CMD_ERASE       = 8'h20;
    localparam logic [7:0] CMD_CONFIRM     = 8'hD0;

    // Status register bit positions
    localparam int SR_READY       = 7;
    localparam int SR_ERASE_ERR   = 5;
    localparam int SR_PROG_ERR    = 4;
    localparam int SR_PROTECT_ERR = 1;

    // Identifier bytes returned in READ_ID mode at addresses 0 and 1
    localparam logic [7:0] ID_MANUFACTURER = 8'h89;
    localparam logic [7:0] ID_DEVICE       = 8'h18;

    // Command state encoding
    localparam logic [2:0] ST_READ_ARRAY  = 3'd0;
    localparam logic [2:0] ST_READ_STATUS = 3'd1;
    localparam logic [2:0] ST_READ_ID     = 3'd2;
    localparam logic [2:0] ST_WAIT_PROG   = 3'd3;
    localparam logic [2:0] ST_WAIT_ERASE  = 3'd4;
    localparam logic [2:0] ST_BUSY_PROG   = 3'd5;
    localparam logic [2:0] ST_BUSY_ERASE  = 3'd6;

    // True while an internal program or erase operation is running
    function automatic logic isBusyState(input logic [2:0] state);
        return (state == ST_BUSY_PROG) || (state == ST_BUSY_ERASE);
    endfunction

    // Assemble the status register; all undefined bits read as 0
    function automatic logic [7:0] statusByte(input logic ready,
                                              input logic eraseErr,
                                              input logic progErr,
                                              input logic protectErr);
        logic [7:0] sr;
        sr                 = 8'h00;
        sr[SR_READY]       = ready;
        sr[SR_ERASE_ERR]   = eraseErr;
        sr[SR_PROG_ERR]    = progErr;
        sr[SR_PROTECT_ERR] = protectErr;
        return sr;
    endfunction

endpackage

// File: rtl/flash_busy_counter.sv
// ----------------------------------------------------------------------------
// flash_busy_counter
// Loadable down-counter that times the busy period of a program or erase.
// Loading value N-1 makes o_done assert on the N-th clock edge after the load
// edge, so the owner stays busy for exactly N cycles.
// Ports:
//   i_clk    clock
//   i_rst    asynchronous active-high reset
//   i_clear  synchronous clear (device power-down line)
//   i_load   load i_value and start counting
//   i_value  cycle count minus one
//   o_done   high during the final counted cycle
// ----------------------------------------------------------------------------
module flash_busy_counter #(
    parameter int MAX_COUNT = 64
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_clear,
    input  logic                           i_load,
    input  logic [$clog2(MAX_COUNT+1)-1:0] i_value,
    output logic                           o_done
);

    localparam int CNT_W = $clog2(MAX_COUNT + 1);

    logic [CNT_W-1:0] r_count;
    logic             r_active;

    // The counter runs only after a load; it parks idle once it reaches zero
    // so o_done is a single-cycle pulse per operation.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count  <= '0;
            r_active <= 1'b0;
        end else if (i_clear) begin
            r_count  <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_count  <= i_value;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_count == '0) begin
                r_active <= 1'b0;
            end else begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_done = r_active && (r_count == '0);

endmodule

// File: rtl/flash_responder.sv
// ----------------------------------------------------------------------------
// flash_responder
// Device end of the parallel NOR flash bus: byte array, command state machine,
// status register and busy/ready STS line. Stands in for the StrataFlash so
// the controller can be exercised end to end.
// Ports:
//   CLK_50MHZ  system clock, all NF_* inputs sampled on its rising edge
//   RST        asynchronous active-high reset
//   NF_CE/OE/WE/RP/WP  active-low bus controls
//   NF_BYTE    bus width select (ignored, byte-wide device)
//   NF_A       address
//   NF_D_IN    data from controller
//   NF_D_OUT   data to controller
//   NF_D_OE    drive enable for NF_D_OUT
//   NF_STS     1 = ready, 0 = busy
// ----------------------------------------------------------------------------
module flash_responder
    import flash_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int BLOCK_W      = 4,
    parameter int PROG_CYCLES  = 16,
    parameter int ERASE_CYCLES = 64
) (
    input  logic              CLK_50MHZ,
    input  logic              RST,
    input  logic              NF_CE,
    input  logic              NF_OE,
    input  logic              NF_WE,
    input  logic              NF_RP,
    input  logic              NF_WP,
    input  logic              NF_BYTE,
    input  logic [ADDR_W-1:0] NF_A,
    input  logic [7:0]        NF_D_IN,
    output logic [7:0]        NF_D_OUT,
    output logic              NF_D_OE,
    output logic              NF_STS
);

    localparam int MAX_CYCLES  = (PROG_CYCLES > ERASE_CYCLES) ? PROG_CYCLES : ERASE_CYCLES;
    localparam int CNT_W       = $clog2(MAX_CYCLES + 1);
    localparam int DEPTH       = 1 << ADDR_W;
    localparam int BLOCK_BYTES = 1 << BLOCK_W;

    // The array holds the inverted byte value. Uninitialised RAM comes up as
    // zeros, which therefore reads back as the erased value 0xFF without any
    // reset or init logic touching the array. Programming ORs in cleared bits,
    // erasing writes zeros.
    logic [7:0]        r_mem_n [DEPTH];

    logic [2:0]        r_state;
    logic              r_erase_err;
    logic              r_prog_err;
    logic              r_protect_err;
    logic              r_we_prev;
    logic [ADDR_W-1:0] r_lat_a;
    logic [7:0]        r_lat_d;
    logic [ADDR_W-1:0] r_op_a;
    logic [7:0]        r_op_d;
    logic [7:0]        r_d_out;
    logic              r_d_oe;

    logic              w_ready;
    logic              w_write_event;
    logic              w_read_sample;
    logic              w_cnt_load;
    logic [CNT_W-1:0]  w_cnt_value;
    logic              w_cnt_done;
    logic              w_apply;
    logic [7:0]        w_status;
    logic [7:0]        w_read_byte;
    logic              w_unused_byte;

    assign w_unused_byte = NF_BYTE;

    assign w_ready       = !isBusyState(r_state);
    assign NF_STS        = w_ready;
    assign NF_D_OUT      = r_d_out;
    assign NF_D_OE       = r_d_oe;

    // A write event is the sampled rising edge of WE while the chip is selected
    assign w_write_event = !NF_CE && NF_WE && !r_we_prev;
    // Reads are suppressed whenever WE is low so the write path always wins
    assign w_read_sample = !NF_CE && !NF_OE && NF_WE;
    assign w_status      = statusByte(w_ready, r_erase_err, r_prog_err, r_protect_err);
    // Power-down must also block the array update that would land this edge
    assign w_apply       = w_cnt_done && NF_RP && isBusyState(r_state);

    // Start the busy timer only for a committing write that is not protected
    always_comb begin
        w_cnt_load  = 1'b0;
        w_cnt_value = '0;
        if (w_write_event && NF_WP) begin
            if (r_state == ST_WAIT_PROG) begin
                w_cnt_load  = 1'b1;
                w_cnt_value = CNT_W'(PROG_CYCLES - 1);
            end else if ((r_state == ST_WAIT_ERASE) && (r_lat_d == CMD_CONFIRM)) begin
                w_cnt_load  = 1'b1;
                w_cnt_value = CNT_W'(ERASE_CYCLES - 1);
            end
        end
    end

    // Select what a read returns in the current mode; every mode other than
    // array and identifier reads presents the status register
    always_comb begin
        w_read_byte = w_status;
        case (r_state)
            ST_READ_ARRAY: w_read_byte = ~r_mem_n[NF_A];
            ST_READ_ID: begin
                if (NF_A == '0) begin
                    w_read_byte = ID_MANUFACTURER;
                end else if (NF_A == ADDR_W'(1)) begin
                    w_read_byte = ID_DEVICE;
                end else begin
                    w_read_byte = 8'h00;
                end
            end
            default: w_read_byte = w_status;
        endcase
    end

    flash_busy_counter #(
        .MAX_COUNT(MAX_CYCLES)
    ) u_busy_counter (
        .i_clk  (CLK_50MHZ),
        .i_rst  (RST),
        .i_clear(!NF_RP),
        .i_load (w_cnt_load),
        .i_value(w_cnt_value),
        .o_done (w_cnt_done)
    );

    // Command state machine, bus latches and registered read port. NF_RP low
    // behaves like RST but takes effect on the clock edge and holds while low.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            r_state       <= ST_READ_ARRAY;
            r_erase_err   <= 1'b0;
            r_prog_err    <= 1'b0;
            r_protect_err <= 1'b0;
            r_we_prev     <= 1'b1;
            r_lat_a       <= '0;
            r_lat_d       <= 8'h00;
            r_op_a        <= '0;
            r_op_d        <= 8'h00;
            r_d_out       <= 8'h00;
            r_d_oe        <= 1'b0;
        end else if (!NF_RP) begin
            r_state       <= ST_READ_ARRAY;
            r_erase_err   <= 1'b0;
            r_prog_err    <= 1'b0;
            r_protect_err <= 1'b0;
            r_we_prev     <= 1'b1;
            r_lat_a       <= '0;
            r_lat_d       <= 8'h00;
            r_op_a        <= '0;
            r_op_d        <= 8'h00;
            r_d_out       <= 8'h00;
            r_d_oe        <= 1'b0;
        end else begin
            r_we_prev <= NF_WE;
            if (!NF_CE && !NF_WE) begin
                r_lat_a <= NF_A;
                r_lat_d <= NF_D_IN;
            end
            r_d_oe <= w_read_sample;
            if (w_read_sample) begin
                r_d_out <= w_read_byte;
            end

            case (r_state)
                ST_READ_ARRAY, ST_READ_STATUS, ST_READ_ID: begin
                    if (w_write_event) begin
                        case (r_lat_d)
                            CMD_READ_ARRAY:  r_state <= ST_READ_ARRAY;
                            CMD_READ_STATUS: r_state <= ST_READ_STATUS;
                            CMD_READ_ID:     r_state <= ST_READ_ID;
                            CMD_CLEAR_SR: begin
                                r_erase_err   <= 1'b0;
                                r_prog_err    <= 1'b0;
                                r_protect_err <= 1'b0;
                            end
                            CMD_PROGRAM, CMD_PROGRAM_ALT: r_state <= ST_WAIT_PROG;
                            CMD_ERASE:       r_state <= ST_WAIT_ERASE;
                            default:         r_state <= r_state;
                        endcase
                    end
                end
                ST_WAIT_PROG: begin
                    if (w_write_event) begin
                        if (!NF_WP) begin
                            r_protect_err <= 1'b1;
                            r_prog_err    <= 1'b1;
                            r_state       <= ST_READ_STATUS;
                        end else begin
                            r_op_a  <= r_lat_a;
                            r_op_d  <= r_lat_d;
                            r_state <= ST_BUSY_PROG;
                        end
                    end
                end
                ST_WAIT_ERASE: begin
                    if (w_write_event) begin
                        if (r_lat_d != CMD_CONFIRM) begin
                            r_erase_err <= 1'b1;
                            r_prog_err  <= 1'b1;
                            r_state     <= ST_READ_STATUS;
                        end else if (!NF_WP) begin
                            r_protect_err <= 1'b1;
                            r_erase_err   <= 1'b1;
                            r_state       <= ST_READ_STATUS;
                        end else begin
                            r_op_a  <= r_lat_a;
                            r_state <= ST_BUSY_ERASE;
                        end
                    end
                end
                ST_BUSY_PROG, ST_BUSY_ERASE: begin
                    if (w_cnt_done) begin
                        r_state <= ST_READ_STATUS;
                    end
                end
                default: r_state <= ST_READ_ARRAY;
            endcase
        end
    end

    // Array update lands on the same edge that ends the busy period, so the
    // new content is readable as soon as STS returns high. No reset here: the
    // array survives both RST and NF_RP.
    always_ff @(posedge CLK_50MHZ) begin
        if (w_apply) begin
            if (r_state == ST_BUSY_PROG) begin
                r_mem_n[r_op_a] <= r_mem_n[r_op_a] | ~r_op_d;
            end else begin
                for (int i = 0; i < BLOCK_BYTES; i++) begin
                    r_mem_n[{r_op_a[ADDR_W-1:BLOCK_W], BLOCK_W'(i)}] <= 8'h00;
                end
            end
        end
    end

endmodule
